// File: rtl/axi_pkg.sv
// Shared constants and state encodings for the AXI4 memory responder.
package axi_pkg;
  localparam int BEAT_BYTES = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word index for an AXI burst (FIXED / INCR / WRAP); unsupported WRAP lengths fall back to INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic [IDX_W-1:0] cur,
  input  logic [IDX_W-1:0] start,
  input  logic [7:0]       len,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next
);
  logic [IDX_W-1:0] inc;
  logic [IDX_W-1:0] mask;
  logic             wrap_ok;

  always_comb begin
    inc     = cur + {{(IDX_W-1){1'b0}}, 1'b1};
    mask    = {{(IDX_W-4){1'b0}}, len[3:0]};
    wrap_ok = (burst == BURST_WRAP) &&
              (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    if (burst == BURST_FIXED)
      next = cur;
    else if (wrap_ok)
      next = (start & ~mask) | (inc & mask);
    else
      next = inc;
  end
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave word memory with fixed read latency and independent read/write burst engines.
//
// state   | meaning
// R_IDLE  | arready high, waiting for a read burst
// R_WAIT  | latency countdown; first beat loaded on terminal count
// R_BURST | rvalid high, beats advance on rready
// W_IDLE  | awready high, waiting for a write burst
// W_DATA  | wready high, one memory write per W beat
// W_RESP  | bvalid high until bready
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [ID_W-1:0]       arid,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic [ID_W-1:0]       rid,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [ID_W-1:0]       awid,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [BEAT_BYTES-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic [ID_W-1:0]       bid,
  output logic                  bvalid,
  input  logic                  bready
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  rd_state_t        r_state, r_next;
  logic [IDX_W-1:0] r_idx, r_start, r_idx_nxt;
  logic [7:0]       r_len, r_beat;
  logic [1:0]       r_burst;
  logic [ID_W-1:0]  r_id;
  logic [3:0]       r_lat;

  wr_state_t        w_state, w_next;
  logic [IDX_W-1:0] w_idx, w_start, w_idx_nxt;
  logic [7:0]       w_len, w_beat;
  logic [1:0]       w_burst;
  logic [ID_W-1:0]  w_id;
  logic             w_err, w_err_nxt, w_final;

  // Size and out-of-range address bits are intentionally ignored (aliasing).
  logic unused_ok;
  assign unused_ok = ^{arsize, awsize, araddr[ADDR_W-1:IDX_W+2], araddr[1:0],
                       awaddr[ADDR_W-1:IDX_W+2], awaddr[1:0]};

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_addr (
    .cur(r_idx), .start(r_start), .len(r_len), .burst(r_burst), .next(r_idx_nxt)
  );

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_addr (
    .cur(w_idx), .start(w_start), .len(w_len), .burst(w_burst), .next(w_idx_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_WAIT;
      end
      R_WAIT:  if (r_lat == 4'd0) r_next = R_BURST;
      R_BURST: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // R outputs are registered so they hold while rready is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= BURST_FIXED;
      r_id    <= '0;
      r_lat   <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_idx   <= araddr[IDX_W+1:2];
          r_start <= araddr[IDX_W+1:2];
          r_len   <= arlen;
          r_burst <= arburst;
          r_id    <= arid;
          r_beat  <= '0;
          r_lat   <= 4'(RD_LATENCY);
        end
        R_WAIT: if (r_lat == 4'd0) begin
          rdata <= mem[r_idx];
          rlast <= (r_len == 8'd0);
          rresp <= (r_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
          rid   <= r_id;
        end else begin
          r_lat <= r_lat - 4'd1;
        end
        R_BURST: if (rready) begin
          if (rlast) begin
            rlast <= 1'b0;
          end else begin
            r_idx  <= r_idx_nxt;
            r_beat <= r_beat + 8'd1;
            rdata  <= mem[r_idx_nxt];
            rlast  <= ((r_beat + 8'd1) == r_len);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_final   = (w_beat == w_len);
  assign w_err_nxt = w_err | (wlast != w_final);

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_idx   <= '0;
      w_start <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= BURST_FIXED;
      w_id    <= '0;
      w_err   <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_idx   <= awaddr[IDX_W+1:2];
          w_start <= awaddr[IDX_W+1:2];
          w_len   <= awlen;
          w_burst <= awburst;
          w_id    <= awid;
          w_beat  <= '0;
          w_err   <= 1'b0;
        end
        W_DATA: if (wvalid) begin
          w_idx  <= w_idx_nxt;
          w_beat <= w_beat + 8'd1;
          w_err  <= w_err_nxt;
          if (w_final) begin
            bresp <= (w_err_nxt || w_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
            bid   <= w_id;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (w_state == W_DATA && wvalid && w_burst != BURST_RSVD) begin
      for (int b = 0; b < BEAT_BYTES; b++)
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule
